// File: rtl/dmem_ctrl.sv
// dmem_ctrl: wait-stated data memory with a request/ready handshake and
// byte/halfword/word loads and stores on a word-organised array.
//
// Ports:
//   Clk, Rst_n   clock, asynchronous active-low reset
//   Req          access request, sampled only while Busy=0
//   WrEn         1=store, 0=load (sampled with Req)
//   Size         00 byte, 01 halfword, 1x word
//   Unsigned     1=zero-extend sub-word loads, 0=sign-extend
//   Address      byte address; word index = Address[ADDR_WIDTH+1:2]
//   WriteData    store data, right-justified for byte/half
//   ReadData     registered load result, held until the next load completes
//   Ready        one-cycle completion pulse
//   Misaligned   valid with Ready; 1 = request rejected
//   Busy         high whenever the controller is not idle
module dmem_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Req,
  input  logic        WrEn,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        Misaligned,
  output logic        Busy
);

  localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
  localparam int unsigned LOW_W  = ADDR_WIDTH + 2;
  localparam int unsigned CNT_W  = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  typedef struct packed {
    logic             wr;
    logic [1:0]       size;
    logic             uns;
    logic [LOW_W-1:0] addr;
    logic [31:0]      wdata;
  } req_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  req_t             req_q;
  logic             mis_q;

  logic [31:0]      mem [DEPTH];

  logic             mis_in_c;
  logic [1:0]       lane_c;
  logic [ADDR_WIDTH-1:0] widx_c;
  logic [3:0]       be_c;
  logic [31:0]      wword_c;
  logic [31:0]      rshift_c;
  logic [31:0]      load_c;
  logic             do_write_c;
  logic             addr_unused;

  // Address bits above the word index alias onto the array.
  assign addr_unused = ^Address[31:LOW_W];

  // Alignment of the request being presented (identical to the latched copy).
  assign mis_in_c = ((Size == 2'b01) && Address[0]) ||
                    (Size[1] && (Address[1:0] != 2'b00));

  // Lane enables, replicated write data and formatted load for the latched request.
  always_comb begin
    lane_c   = req_q.addr[1:0];
    widx_c   = req_q.addr[LOW_W-1:2];
    be_c     = 4'b1111;
    wword_c  = req_q.wdata;
    rshift_c = mem[widx_c] >> {lane_c, 3'b000};
    load_c   = rshift_c;
    case (req_q.size)
      2'b00: begin
        be_c    = 4'b0001 << lane_c;
        wword_c = {4{req_q.wdata[7:0]}};
        load_c  = req_q.uns ? {24'h0, rshift_c[7:0]}
                            : {{24{rshift_c[7]}}, rshift_c[7:0]};
      end
      2'b01: begin
        be_c    = 4'b0011 << lane_c;
        wword_c = {2{req_q.wdata[15:0]}};
        load_c  = req_q.uns ? {16'h0, rshift_c[15:0]}
                            : {{16{rshift_c[15]}}, rshift_c[15:0]};
      end
      default: begin
        be_c    = 4'b1111;
        wword_c = req_q.wdata;
        load_c  = rshift_c;
      end
    endcase
  end

  assign do_write_c = (state == S_ACCESS) && !mis_q && req_q.wr;

  // Byte-lane writes; the array itself is never reset.
  always_ff @(posedge Clk) begin
    if (do_write_c) begin
      for (int k = 0; k < 4; k++) begin
        if (be_c[k]) mem[widx_c][8*k +: 8] <= wword_c[8*k +: 8];
      end
    end
  end

  // Controller FSM with registered handshake outputs.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      req_q      <= '0;
      mis_q      <= 1'b0;
      Ready      <= 1'b0;
      Misaligned <= 1'b0;
      ReadData   <= '0;
      Busy       <= 1'b0;
    end else begin
      Ready      <= 1'b0;
      Misaligned <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Req) begin
            req_q <= '{wr: WrEn, size: Size, uns: Unsigned,
                       addr: Address[LOW_W-1:0], wdata: WriteData};
            mis_q <= mis_in_c;
            Busy  <= 1'b1;
            if (mis_in_c || (WAIT_STATES == 0)) begin
              state <= S_ACCESS;
            end else begin
              state <= S_WAIT;
              cnt   <= CNT_W'(WAIT_STATES - 1);
            end
          end
        end
        S_WAIT: begin
          if (cnt == '0) state <= S_ACCESS;
          else           cnt   <= cnt - CNT_W'(1);
        end
        S_ACCESS: begin
          Ready      <= 1'b1;
          Misaligned <= mis_q;
          Busy       <= 1'b0;
          state      <= S_IDLE;
          if (mis_q)          ReadData <= '0;
          else if (!req_q.wr) ReadData <= load_c;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised, wait-stated data memory for the multicycle CPU. It replaces the zero-latency word-only data memory with a request/ready handshake, a configurable access latency and byte/halfword/word loads and stores. Byte-lane write enables are applied to a word-organised array. It sits between the CPU datapath/control FSM and the data store; the control FSM stalls on Busy/Ready.

## Interface

- ADDR_WIDTH, 8: log2 of the number of 32-bit words (256 words by default).
- WAIT_STATES, 2: extra cycles inserted before each access (0 allowed).
- Clk  in  1  clock; all state changes on posedge.
- Rst_n  in  1  asynchronous, active-low reset.
- Req  in  1  access request; sampled only when Busy=0.
- WrEn  in  1  1=store, 0=load; sampled with Req.
- Size  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- Unsigned  in  1  1=zero-extend sub-word loads, 0=sign-extend.
- Address  in  32  byte address; word index = Address[ADDR_WIDTH+1:2], upper bits ignored (aliasing).
- WriteData  in  32  store data, right-justified for byte/half.
- ReadData  out  32  registered load result; holds until the next load completes.
- Ready  out  1  one-cycle completion pulse.
- Misaligned  out  1  valid with Ready; 1 = request rejected.
- Busy  out  1  high whenever the state is not IDLE.

## Operation

- States: IDLE, WAIT, ACCESS. Busy = (state != IDLE).
- IDLE + Req=1 at a posedge: latch Address, WriteData, WrEn, Size, Unsigned.
  - Alignment is checked on the latched values. Misaligned cases: half with Address[0]=1; word with Address[1:0]≠0.
  - Misaligned → ACCESS directly, with the access suppressed.
  - Aligned and WAIT_STATES>0 → WAIT, with counter = WAIT_STATES-1.
  - Aligned and WAIT_STATES=0 → ACCESS.
- WAIT: if counter=0 → ACCESS; else decrement. WAIT lasts exactly WAIT_STATES cycles.
- ACCESS: one cycle. At its closing posedge:
  - Store (aligned): write enabled byte lanes only.
  - Load (aligned): ReadData <= formatted result.
  - Misaligned: ReadData <= 0, no write.
  - All cases: Ready <= 1, Misaligned <= flag, state → IDLE.
- Ready and Misaligned are high for exactly the one cycle after ACCESS, then return to 0.
- Store responses leave ReadData unchanged.
- Byte lanes are little-endian: lane k = bits [8k+7:8k], k = Address[1:0].
  - Byte store: WriteData[7:0] → lane k.
  - Half store: WriteData[15:0] → lanes k, k+1 (k ∈ {0,2}).
  - Word store: all four lanes.
- Loads select the same lanes and right-justify them. Bits above are zero-filled (Unsigned=1) or copies of the top loaded bit (Unsigned=0). Word loads ignore Unsigned.
- Memory array is not reset; unwritten contents are undefined (X in simulation).

## Timing

- Reset (asynchronous, immediate): state IDLE, counter 0, Ready 0, Misaligned 0, ReadData 0, Busy 0.
- Reset asserted mid-operation aborts the request. No write occurs unless the ACCESS closing edge already happened. Memory contents are preserved.
- Latency for aligned requests: Req sampled at edge E → Ready high in the cycle after edge E+WAIT_STATES+1.
- Latency for misaligned requests: Ready high after edge E+1, regardless of WAIT_STATES.
- Req while Busy=1 is ignored; the requester must hold or re-present it.
- Back-to-back: Req may be asserted in the Ready cycle (state is IDLE). It is accepted at that cycle's closing edge, so there is no dead cycle.
- Busy rises in the cycle after acceptance and falls in the Ready cycle.
- Address alias: word index wraps modulo 2^ADDR_WIDTH; no error is flagged.

## Test plan

- Reset then idle: Rst_n low 3 cycles → Ready=0, Misaligned=0, ReadData=0, Busy=0.
- Word round trip, WAIT_STATES=2:
  - Store 0xDEADBEEF @0x10 → Ready 3 cycles after accept, Busy high 3 cycles.
  - Load @0x10 → ReadData=0xDEADBEEF, Misaligned=0.
- Byte/half lanes:
  - Word 0x00000000 @0x20; then byte 0x80 @0x21; then half 0xF00D @0x22.
  - Word load @0x20 → 0xF00D8000.
  - Signed byte load @0x21 → 0xFFFFFF80; unsigned byte load → 0x00000080.
  - Signed half load @0x22 → 0xFFFFF00D.
- Misalignment:
  - Word store @0x31 → Ready after 1 edge, Misaligned=1, ReadData=0.
  - Subsequent word load @0x30 returns the prior contents, unchanged.
  - Half load @0x33 → Misaligned=1.
- Handshake stress, WAIT_STATES=0:
  - Req held high for 4 aligned loads → 4 Ready pulses on consecutive alternating cycles, no request lost.
  - Req pulsed while Busy → ignored, no extra Ready.
- Reset mid-op: assert Rst_n=0 during WAIT of a store to 0x40 → word @0x40 keeps its previous value; outputs return to reset values immediately.
